// File: rtl/card_dealer.sv
// Card dealer: captures the 52-card shuffle stream into a local deck, then deals
// cards on a request/valid handshake with rank/suit/points decode. Build with
// DUP_CHECK_EN defined to reject out-of-range or repeated cards during capture.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_LOAD  | capturing upstream cards, shuffle requested
// S_READY | deck captured, serving deal requests
// S_EMPTY | every captured card dealt, held until reset
// S_ERROR | bad capture seen (DUP_CHECK_EN only), held until reset
module card_dealer #(
    parameter int DECK_SIZE     = 52,
    parameter int LOAD_INTERVAL = 4,
    parameter int CARD_W        = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_flag,
    input  logic [CARD_W-1:0] i_card_in,
    output logic              o_shuffle_flag,
    input  logic              i_deal_req,
    output logic              o_deal_ready,
    output logic              o_deal_valid,
    output logic [CARD_W-1:0] o_card_out,
    output logic [3:0]        o_card_rank,
    output logic [1:0]        o_card_suit,
    output logic [3:0]        o_card_points,
    output logic [5:0]        o_cards_remaining,
    output logic              o_deck_empty,
    output logic              o_load_err
);

    localparam int PW = 6;
    localparam int TW = (LOAD_INTERVAL > 1) ? $clog2(LOAD_INTERVAL) : 1;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_EMPTY = 2'd2
`ifdef DUP_CHECK_EN
        , S_ERROR = 2'd3
`endif
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [TW-1:0]     r_ld_tmr;
    logic [CARD_W-1:0] r_deck [DECK_SIZE];

    logic              w_capture;
    logic              w_wr_en;
    logic [CARD_W-1:0] w_rd_code;
    logic [3:0]        w_rank;
    logic [1:0]        w_suit;
    logic [3:0]        w_points;

    // The load timer counts down; a capture happens on its terminal count.
    assign w_capture = (r_state == S_LOAD) && i_load_flag && (r_ld_tmr == '0);

`ifdef DUP_CHECK_EN
    logic [DECK_SIZE-1:0] r_seen;
    logic                 r_load_err;
    logic                 w_bad;

    assign w_bad      = (32'(i_card_in) >= DECK_SIZE) || r_seen[i_card_in];
    assign w_wr_en    = w_capture && !w_bad;
    assign o_load_err = r_load_err;
`else
    assign w_wr_en    = w_capture;
    assign o_load_err = 1'b0;
`endif

    assign w_rd_code = r_deck[r_rd_ptr];
    assign w_suit    = 2'(w_rd_code / CARD_W'(13));
    assign w_rank    = 4'(w_rd_code % CARD_W'(13)) + 4'd1;
    assign w_points  = (w_rank == 4'd1) ? 4'd11 : (w_rank > 4'd10) ? 4'd10 : w_rank;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_deck[r_wr_ptr] <= i_card_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= S_LOAD;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_ld_tmr          <= TW'(LOAD_INTERVAL - 1);
            o_shuffle_flag    <= 1'b1;
            o_deal_ready      <= 1'b0;
            o_deal_valid      <= 1'b0;
            o_card_out        <= '0;
            o_card_rank       <= '0;
            o_card_suit       <= '0;
            o_card_points     <= '0;
            o_cards_remaining <= '0;
            o_deck_empty      <= 1'b0;
`ifdef DUP_CHECK_EN
            r_seen            <= '0;
            r_load_err        <= 1'b0;
`endif
        end else begin
            o_deal_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (i_load_flag) begin
                        if (r_ld_tmr == '0) begin
                            r_ld_tmr <= TW'(LOAD_INTERVAL - 1);
                        end else begin
                            r_ld_tmr <= r_ld_tmr - 1'b1;
                        end
                    end
                    if (w_wr_en) begin
                        r_wr_ptr          <= r_wr_ptr + 1'b1;
                        o_cards_remaining <= o_cards_remaining + 1'b1;
`ifdef DUP_CHECK_EN
                        r_seen[i_card_in] <= 1'b1;
`endif
                        if (r_wr_ptr == PW'(DECK_SIZE - 1)) begin
                            r_state        <= S_READY;
                            o_shuffle_flag <= 1'b0;
                            o_deal_ready   <= 1'b1;
                        end
                    end
`ifdef DUP_CHECK_EN
                    if (w_capture && w_bad) begin
                        r_state        <= S_ERROR;
                        r_load_err     <= 1'b1;
                        o_shuffle_flag <= 1'b0;
                    end
`endif
                end
                S_READY: begin
                    if (i_deal_req && o_deal_ready) begin
                        o_deal_valid      <= 1'b1;
                        o_card_out        <= w_rd_code;
                        o_card_rank       <= w_rank;
                        o_card_suit       <= w_suit;
                        o_card_points     <= w_points;
                        r_rd_ptr          <= r_rd_ptr + 1'b1;
                        o_cards_remaining <= o_cards_remaining - 1'b1;
                        if (o_cards_remaining == 6'd1) begin
                            r_state      <= S_EMPTY;
                            o_deal_ready <= 1'b0;
                            o_deck_empty <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: table-driven decode vectors plus random
// decks and handshake traffic checked against a queue-based deck model.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_flag = 1'b0;
    logic       deal_req = 1'b0;
    logic [5:0] card_in = '0;
    logic       shuffle_flag, deal_ready, deal_valid, deck_empty, load_err;
    logic [5:0] card_out, cards_remaining;
    logic [3:0] card_rank, card_points;
    logic [1:0] card_suit;

    card_dealer dut (
        .i_clk(clk), .i_rst(rst), .i_load_flag(load_flag), .i_card_in(card_in),
        .o_shuffle_flag(shuffle_flag), .i_deal_req(deal_req), .o_deal_ready(deal_ready),
        .o_deal_valid(deal_valid), .o_card_out(card_out), .o_card_rank(card_rank),
        .o_card_suit(card_suit), .o_card_points(card_points),
        .o_cards_remaining(cards_remaining), .o_deck_empty(deck_empty), .o_load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int rank;
        int suit;
        int points;
    } vec_t;

    int errs = 0;
    int checks = 0;
    int q[$];
    int last_code, last_rank, last_suit, last_pts;
    int pts_of_rank[14] = '{0, 11, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10};

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_flag = 1'b0; deal_req = 1'b0; card_in = '0;
        @(negedge clk);
        chk("rst_shuffle", shuffle_flag, 1);
        chk("rst_ready", deal_ready, 0);
        chk("rst_valid", deal_valid, 0);
        chk("rst_remaining", cards_remaining, 0);
        chk("rst_empty", deck_empty, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_card", card_out, 0);
        chk("rst_rank", card_rank, 0);
        chk("rst_suit", card_suit, 0);
        chk("rst_points", card_points, 0);
        rst = 1'b0;
        q.delete();
        last_code = 0; last_rank = 0; last_suit = 0; last_pts = 0;
    endtask

    // Upstream holds each card until it is captured; captures fall on every
    // LOAD_INTERVAL-th cycle with load_flag high.
    task automatic load_deck(input int codes[52], input bit gaps, input bit req_noise, input int n_stop);
        int hi = 0;
        int ncap = 0;
        int cyc = 0;
        while (ncap < n_stop && cyc < 2000) begin
            load_flag = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            card_in   = 6'(codes[ncap]);
            deal_req  = req_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cyc++;
            if (load_flag) begin
                hi++;
                if (hi % 4 == 0) begin
                    q.push_back(codes[ncap]);
                    ncap++;
                end
            end
            chk("ld_remaining", cards_remaining, ncap);
            chk("ld_valid", deal_valid, 0);
            chk("ld_ready", deal_ready, (ncap == 52) ? 1 : 0);
            chk("ld_shuffle", shuffle_flag, (ncap < 52) ? 1 : 0);
            chk("ld_load_err", load_err, 0);
        end
        if (ncap < n_stop) chk("ld_timeout", ncap, n_stop);
        load_flag = 1'b0;
        deal_req  = 1'b0;
    endtask

    task automatic deal(input int ncyc, input bit random_req);
        bit exp_v;
        for (int i = 0; i < ncyc; i++) begin
            deal_req = random_req ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_v = deal_req && (q.size() > 0);
            @(negedge clk);
            chk("dl_valid", deal_valid, exp_v);
            if (exp_v) begin
                last_code = q.pop_front();
                last_rank = last_code % 13 + 1;
                last_suit = last_code / 13;
                last_pts  = pts_of_rank[last_rank];
            end
            chk("dl_card", card_out, last_code);
            chk("dl_rank", card_rank, last_rank);
            chk("dl_suit", card_suit, last_suit);
            chk("dl_points", card_points, last_pts);
            chk("dl_remaining", cards_remaining, q.size());
            chk("dl_ready", deal_ready, (q.size() > 0) ? 1 : 0);
            chk("dl_empty", deck_empty, (q.size() == 0) ? 1 : 0);
        end
        deal_req = 1'b0;
    endtask

    function automatic void rand_perm(output int codes[52]);
        for (int i = 0; i < 52; i++) codes[i] = i;
        for (int i = 51; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            int t = codes[i];
            codes[i] = codes[j];
            codes[j] = t;
        end
    endfunction

    initial begin
        vec_t tbl[7];
        int   codes[52];
        bit   used[52];
        int   n;
        int   dup[3] = '{5, 7, 5};

        tbl[0] = '{0, 1, 0, 11};
        tbl[1] = '{25, 13, 1, 10};
        tbl[2] = '{40, 2, 3, 2};
        tbl[3] = '{51, 13, 3, 10};
        tbl[4] = '{9, 10, 0, 10};
        tbl[5] = '{10, 11, 0, 10};
        tbl[6] = '{13, 1, 1, 11};

        do_reset();

        // Descending deck, deal requests sprinkled through the load.
        for (int i = 0; i < 52; i++) codes[i] = 51 - i;
        load_deck(codes, 1'b0, 1'b1, 52);
        load_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            card_in = 6'($urandom_range(0, 51));
            @(negedge clk);
            chk("post_load_remaining", cards_remaining, 52);
            chk("post_load_shuffle", shuffle_flag, 0);
        end
        load_flag = 1'b0;

        // Held request: 52 pulses, then the 53rd request is dropped.
        deal(53, 1'b0);

        // Reset part-way through a load, then a full reload.
        do_reset();
        rand_perm(codes);
        load_deck(codes, 1'b0, 1'b0, 20);
        do_reset();

        foreach (used[i]) used[i] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            codes[i] = tbl[i].code;
            used[tbl[i].code] = 1'b1;
        end
        n = 7;
        for (int c = 0; c < 52; c++) if (!used[c]) begin codes[n] = c; n++; end
        load_deck(codes, 1'b1, 1'b1, 52);

        for (int i = 0; i < 7; i++) begin
            deal_req = 1'b1;
            @(negedge clk);
            chk("tbl_valid", deal_valid, 1);
            chk("tbl_card", card_out, tbl[i].code);
            chk("tbl_rank", card_rank, tbl[i].rank);
            chk("tbl_suit", card_suit, tbl[i].suit);
            chk("tbl_points", card_points, tbl[i].points);
            last_code = q.pop_front();
            last_rank = tbl[i].rank; last_suit = tbl[i].suit; last_pts = tbl[i].points;
        end
        deal_req = 1'b0;
        deal(200, 1'b1);

        // Random decks with gapped load_flag and random request traffic.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            rand_perm(codes);
            load_deck(codes, 1'b1, 1'b1, 52);
            deal(150, 1'b1);
        end

        // Repeated code in the stream.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            load_flag = 1'b1;
            card_in = 6'(dup[k / 4]);
            @(negedge clk);
        end
`ifdef DUP_CHECK_EN
        chk("dup_load_err", load_err, 1);
        chk("dup_remaining", cards_remaining, 2);
        chk("dup_shuffle", shuffle_flag, 0);
`else
        chk("dup_load_err", load_err, 0);
        chk("dup_remaining", cards_remaining, 3);
        chk("dup_shuffle", shuffle_flag, 1);
`endif
        chk("dup_ready", deal_ready, 0);
        card_in = 6'd9;
        for (int k = 0; k < 8; k++) @(negedge clk);
        load_flag = 1'b0;
`ifdef DUP_CHECK_EN
        chk("dup_hold_remaining", cards_remaining, 2);
        chk("dup_hold_err", load_err, 1);
`else
        chk("dup_hold_remaining", cards_remaining, 5);
        chk("dup_hold_err", load_err, 0);
`endif
        chk("dup_hold_ready", deal_ready, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
